// File: rtl/clk_div_mux.sv
// Programmable clock divider with a selectable ratio table. Ratio changes
// are deferred to a period boundary so clk_out never shows a truncated pulse.
module clk_div_mux #(
    parameter int NUM_DIV = 4,
    parameter int CNT_W   = 8,
    parameter int RST_SEL = 0,
    localparam int SEL_W  = (NUM_DIV > 1) ? $clog2(NUM_DIV) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     sel_req,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_DIV*CNT_W-1:0] div_cfg,
    output logic                     clk_out,
    output logic                     clk_stb,
    output logic                     busy,
    output logic                     sel_ack,
    output logic                     sel_err,
    output logic [SEL_W-1:0]         act_sel
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [SEL_W:0]   NUM_DIV_L = (SEL_W+1)'(NUM_DIV);
    localparam logic [SEL_W-1:0] RST_IDX   = SEL_W'(RST_SEL);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   r_cur_reg;
    logic [SEL_W-1:0]   act_reg;
    logic [SEL_W-1:0]   pend_reg;

    logic [CNT_W-1:0]   ratio [NUM_DIV];

    // Ratios of 0 and 1 cannot form a high and a low phase, so they run as 2.
    generate
        for (genvar gi = 0; gi < NUM_DIV; gi++) begin : g_ratio
            logic [CNT_W-1:0] field;
            assign field     = div_cfg[gi*CNT_W +: CNT_W];
            assign ratio[gi] = (field < CNT_W'(2)) ? CNT_W'(2) : field;
        end
    endgenerate

    logic             sel_ok;
    logic             accept;
    logic             boundary;
    logic [SEL_W-1:0] next_act;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   half_r;
    logic             high_next;

    assign sel_ok    = ({1'b0, sel} < NUM_DIV_L);
    assign accept    = sel_req && !busy && sel_ok;
    assign boundary  = (cnt_reg == r_cur_reg - CNT_W'(1));
    assign next_act  = busy ? pend_reg : act_reg;
    assign cnt_inc   = cnt_reg + CNT_W'(1);
    assign half_r    = ({1'b0, r_cur_reg} + (CNT_W+1)'(1)) >> 1;
    assign high_next = ({1'b0, cnt_inc} < half_r);

    assign act_sel   = act_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            r_cur_reg <= '0;
            act_reg   <= RST_IDX;
            pend_reg  <= RST_IDX;
            busy      <= 1'b0;
            clk_out   <= 1'b0;
            clk_stb   <= 1'b0;
            sel_ack   <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            clk_stb <= 1'b0;
            sel_ack <= 1'b0;
            sel_err <= sel_req && !sel_ok;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    clk_out <= 1'b0;
                    if (accept) begin
                        act_reg  <= sel;
                        pend_reg <= sel;
                        sel_ack  <= 1'b1;
                    end
                    if (en) begin
                        state_reg <= RUN;
                        clk_out   <= 1'b1;
                        clk_stb   <= 1'b1;
                        r_cur_reg <= accept ? ratio[sel] : ratio[act_reg];
                    end
                end
                RUN: begin
                    if (accept) begin
                        pend_reg <= sel;
                        busy     <= 1'b1;
                    end
                    if (boundary) begin
                        if (busy) begin
                            act_reg <= pend_reg;
                            busy    <= 1'b0;
                            sel_ack <= 1'b1;
                        end
                        cnt_reg <= '0;
                        if (en) begin
                            clk_out   <= 1'b1;
                            clk_stb   <= 1'b1;
                            r_cur_reg <= ratio[next_act];
                        end else begin
                            state_reg <= IDLE;
                            clk_out   <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_inc;
                        clk_out <= high_next;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_mux.sv
// Directed bench for clk_div_mux: a 4-ratio instance for the main scenarios
// and a 3-ratio instance for illegal-index and busy-drop behaviour.
module tb_clk_div_mux;

    logic        clk;
    logic        rst_n, rst_b;
    logic        en_a, sel_req_a, en_b, sel_req_b;
    logic [1:0]  sel_a, sel_b;
    logic [31:0] cfg_a;
    logic [23:0] cfg_b;
    logic        clk_out_a, clk_stb_a, busy_a, sel_ack_a, sel_err_a;
    logic        clk_out_b, clk_stb_b, busy_b, sel_ack_b, sel_err_b;
    logic [1:0]  act_a, act_b;

    int total = 0;
    int bad   = 0;

    clk_div_mux #(.NUM_DIV(4), .CNT_W(8), .RST_SEL(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .sel_req(sel_req_a), .sel(sel_a),
        .div_cfg(cfg_a), .clk_out(clk_out_a), .clk_stb(clk_stb_a), .busy(busy_a),
        .sel_ack(sel_ack_a), .sel_err(sel_err_a), .act_sel(act_a)
    );

    clk_div_mux #(.NUM_DIV(3), .CNT_W(8), .RST_SEL(0)) dut_b (
        .clk(clk), .rst_n(rst_b), .en(en_b), .sel_req(sel_req_b), .sel(sel_b),
        .div_cfg(cfg_b), .clk_out(clk_out_b), .clk_stb(clk_stb_b), .busy(busy_b),
        .sel_ack(sel_ack_b), .sel_err(sel_err_b), .act_sel(act_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_r5_clk [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
    int exp_r5_stb [10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int exp_stop   [6]  = '{1, 1, 0, 0, 0, 0};
    int exp_tail   [4]  = '{1, 1, 0, 0};

    initial begin
        rst_n = 1'b0; rst_b = 1'b0;
        en_a = 1'b0; sel_req_a = 1'b0; sel_a = 2'd0;
        en_b = 1'b0; sel_req_b = 1'b0; sel_b = 2'd0;
        cfg_a = {8'd5, 8'd4, 8'd3, 8'd2};
        cfg_b = {8'd4, 8'd3, 8'd0};

        // reset state
        #3;
        chk("rst_clk_out", clk_out_a, 0);
        chk("rst_stb", clk_stb_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_act", act_a, 0);
        en_a = 1'b1;
        #4;
        rst_n = 1'b1; rst_b = 1'b1;

        // R=2 from the first edge after reset release
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("r2_clk[%0d]", i), clk_out_a, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("r2_stb[%0d]", i), clk_stb_a, (i % 2 == 0) ? 1 : 0);
        end
        chk("r2_act", act_a, 0);
        en_a = 1'b0;
        tick();
        chk("r2_idle_clk", clk_out_a, 0);

        // select ratio 3 while idle, then run R=5
        sel_req_a = 1'b1; sel_a = 2'd3;
        tick();
        chk("idle_ack", sel_ack_a, 1);
        chk("idle_act", act_a, 3);
        chk("idle_busy", busy_a, 0);
        sel_req_a = 1'b0;
        tick();
        chk("idle_ack_drop", sel_ack_a, 0);
        en_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("r5_clk[%0d]", i), clk_out_a, exp_r5_clk[i]);
            chk($sformatf("r5_stb[%0d]", i), clk_stb_a, exp_r5_stb[i]);
        end
        en_a = 1'b0;
        tick();
        chk("r5_idle_clk", clk_out_a, 0);

        // run R=4, request ratio 3 during cnt=0: old period must complete
        sel_req_a = 1'b1; sel_a = 2'd2;
        tick();
        chk("sel2_ack", sel_ack_a, 1);
        chk("sel2_act", act_a, 2);
        sel_req_a = 1'b0; en_a = 1'b1;
        tick();
        chk("r4_c0_clk", clk_out_a, 1);
        chk("r4_c0_stb", clk_stb_a, 1);
        sel_req_a = 1'b1; sel_a = 2'd3;
        tick();
        chk("r4_c1_busy", busy_a, 1);
        chk("r4_c1_clk", clk_out_a, 1);
        sel_req_a = 1'b0;
        tick();
        chk("r4_c2_busy", busy_a, 1);
        chk("r4_c2_clk", clk_out_a, 0);
        tick();
        chk("r4_c3_busy", busy_a, 1);
        chk("r4_c3_clk", clk_out_a, 0);
        chk("r4_c3_ack", sel_ack_a, 0);
        chk("r4_c3_act", act_a, 2);
        tick();
        chk("sw_busy", busy_a, 0);
        chk("sw_ack", sel_ack_a, 1);
        chk("sw_act", act_a, 3);
        chk("sw_clk", clk_out_a, 1);
        chk("sw_stb", clk_stb_a, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("sw_clk[%0d]", i + 1), clk_out_a, exp_tail[i]);
            chk($sformatf("sw_ack[%0d]", i + 1), sel_ack_a, 0);
        end

        // drop en at cnt=0 of an R=5 period: period completes, then idle
        tick();
        chk("stop_c0_clk", clk_out_a, 1);
        en_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("stop_clk[%0d]", i + 1), clk_out_a, exp_stop[i]);
            chk($sformatf("stop_stb[%0d]", i + 1), clk_stb_a, 0);
        end
        en_a = 1'b1;
        tick();
        chk("restart_clk", clk_out_a, 1);
        chk("restart_stb", clk_stb_a, 1);

        // async reset mid-high with a switch pending
        sel_req_a = 1'b1; sel_a = 2'd1;
        tick();
        chk("pre_rst_busy", busy_a, 1);
        chk("pre_rst_clk", clk_out_a, 1);
        sel_req_a = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_clk", clk_out_a, 0);
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_act", act_a, 0);

        // 3-ratio instance: clamped ratio 0, ignored busy request, illegal index
        en_b = 1'b1;
        tick();
        chk("b_c0_clk", clk_out_b, 1);
        sel_req_b = 1'b1; sel_b = 2'd1;
        tick();
        chk("b_busy", busy_b, 1);
        chk("b_clamp_clk", clk_out_b, 0);
        sel_b = 2'd2;
        tick();
        chk("b_ignored_err", sel_err_b, 0);
        chk("b_sw_ack", sel_ack_b, 1);
        chk("b_sw_act", act_b, 1);
        chk("b_ignored_busy", busy_b, 0);
        sel_b = 2'd3;
        tick();
        chk("b_err", sel_err_b, 1);
        chk("b_err_act", act_b, 1);
        chk("b_err_busy", busy_b, 0);
        chk("b_err_ack", sel_ack_b, 0);
        sel_req_b = 1'b0;
        tick();
        chk("b_err_drop", sel_err_b, 0);
        chk("b_r3_clk", clk_out_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
